// File: rtl/sap2_serial_loader_if.sv
// Programming-port bundle between the serial loader and the SAP2-mini RAM/CPU.
interface sap2_serial_loader_if;
  logic        prog;
  logic [7:0]  a;
  logic [11:0] d;
  logic        we;
  logic        run;
  logic        done;
  logic        err;
  logic [8:0]  cnt;

  modport master (output prog, a, d, we, run, done, err, cnt);
  modport slave  (input  prog, a, d, we, run, done, err, cnt);
endinterface

// File: rtl/sap2_serial_loader.sv
// 8N1 serial receiver that assembles 3-byte records into SAP2-mini RAM writes,
// releasing prog and pulsing run when an end record arrives.
module sap2_serial_loader #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  rx,
  sap2_serial_loader_if.master  bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  rx_state_t     state, state_n;
  logic          rx_s1, rx_s2;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          timer_rst, shift_en, byte_ok, frame_err;
  logic [1:0]    idx;
  logic [7:0]    b0, b1;

  // Synchronizer resets to the idle line level so clr never looks like a start bit.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    timer_rst = 1'b0;
    shift_en  = 1'b0;
    byte_ok   = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s2) begin
          timer_rst = 1'b1;
          state_n   = START;
        end
      end
      START: begin
        if (timer == T_HALF) begin
          timer_rst = 1'b1;
          state_n   = rx_s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == T_FULL) begin
          timer_rst = 1'b1;
          shift_en  = 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (timer == T_FULL) begin
          state_n   = IDLE;
          byte_ok   = rx_s2;
          frame_err = !rx_s2;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // bit_idx wraps 7 -> 0 on the eighth shift, so it is always 0 on entry to DATA.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      timer <= timer_rst ? '0 : timer + TW'(1);
      if (shift_en) begin
        shreg   <= {rx_s2, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      idx      <= '0;
      b0       <= '0;
      b1       <= '0;
      bus.prog <= 1'b1;
      bus.a    <= '0;
      bus.d    <= '0;
      bus.we   <= 1'b0;
      bus.run  <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      bus.cnt  <= '0;
    end else begin
      bus.we  <= 1'b0;
      bus.run <= 1'b0;
      if (!bus.done) begin
        if (frame_err) begin
          bus.err <= 1'b1;
          idx     <= '0;
        end else if (byte_ok) begin
          case (idx)
            2'd0: begin
              b0  <= shreg;
              idx <= 2'd1;
            end
            2'd1: begin
              b1  <= shreg;
              idx <= 2'd2;
            end
            default: begin
              idx <= '0;
              if (b1[7:4] == 4'h0) begin
                bus.a  <= b0;
                bus.d  <= {b1[3:0], shreg};
                bus.we <= 1'b1;
                if (bus.cnt != '1) bus.cnt <= bus.cnt + 9'd1;
              end else if (b1[7:4] == 4'hF) begin
                bus.prog <= 1'b0;
                bus.run  <= 1'b1;
                bus.done <= 1'b1;
              end else begin
                bus.err <= 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

endmodule
